// File: rtl/udc_pkg.sv
// Shared types and helpers for the up/down counter (up_down_counter_mod).
// Counter widths up to UDC_MAX_WIDTH bits are supported by clamp_to_limit.
package udc_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} udc_dir_t;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} udc_mode_t;

    localparam int UDC_MAX_WIDTH = 32;

    // Loaded values never exceed the programmed limit.
    function automatic logic [UDC_MAX_WIDTH-1:0] clamp_to_limit(
        input logic [UDC_MAX_WIDTH-1:0] val,
        input logic [UDC_MAX_WIDTH-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-step calculator for the up/down counter.
// Works one bit wider than the counter so the increment carry and the
// decrement borrow are observed internally but never leak to the count.
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  udc_dir_t         direction,
    input  udc_mode_t        mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] limit_ext;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    // Extended operands; dec[WIDTH] is the borrow, set only when count==0.
    always_comb begin
        count_ext = {1'b0, count};
        limit_ext = {1'b0, limit};
        inc       = count_ext + ONE;
        dec       = count_ext - ONE;
    end

    // One step in the requested direction, bounded by 0..limit.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (direction == DIR_UP) begin
            if (inc <= limit_ext) begin
                next_count = inc[WIDTH-1:0];
            end else if (mode == MODE_WRAP) begin
                next_count = '0;
                wrap       = 1'b1;
            end else begin
                next_count = limit;
            end
        end else begin
            if (count_ext > limit_ext) begin
                // limit was lowered below the count: snap down, never wrap
                next_count = limit;
            end else if (!dec[WIDTH]) begin
                next_count = dec[WIDTH-1:0];
            end else if (mode == MODE_WRAP) begin
                next_count = limit;
                wrap       = 1'b1;
            end else begin
                next_count = '0;
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with programmable limit, wrap/saturate
// mode and parallel load. Range is 0..limit inclusive.
// Optional compare output enabled by defining UDC_CMP_EN
// (adds input cmp_val and registered one-shot output cmp_hit).
// WIDTH must be in 2..32; RESET_VAL must not exceed any limit in use.
module up_down_counter_mod
    import udc_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    input  logic             up_en,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
`ifdef UDC_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse
);

    udc_dir_t         dir;
    udc_mode_t        mode;
    logic [WIDTH-1:0] step_count;
    logic             step_wrap;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;

    // Map raw control bits onto the typed direction/mode.
    always_comb begin
        dir  = up_en ? DIR_UP : DIR_DOWN;
        mode = sat_mode ? MODE_SAT : MODE_WRAP;
    end

    udc_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .count      (count),
        .limit      (limit),
        .direction  (dir),
        .mode       (mode),
        .next_count (step_count),
        .wrap       (step_wrap)
    );

    // Load value limited to the current range.
    always_comb begin
        load_clamped = WIDTH'(clamp_to_limit(UDC_MAX_WIDTH'(load_val),
                                             UDC_MAX_WIDTH'(limit)));
    end

    // Priority mux: load beats counting, otherwise hold with no pulse.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (load_en) begin
            count_d = load_clamped;
        end else if (count_en) begin
            count_d = step_count;
            wrap_d  = step_wrap;
        end
    end

    // Count and wrap pulse registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= RESET_VAL;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= count_d;
            wrap_pulse <= wrap_d;
        end
    end

    // Terminal count follows the live direction select.
    always_comb begin
        tc = up_en ? (count >= limit) : (count == '0);
    end

`ifdef UDC_CMP_EN
    // Pulse only on arrival at cmp_val, not while sitting on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_hit <= 1'b0;
        end else begin
            cmp_hit <= (count_d == cmp_val) && (count != cmp_val);
        end
    end
`endif

endmodule
